// File: rtl/ps2_voice_allocator_if.sv
// ps2_voice_allocator_if
//
// Groups the scancode input and the voice-state outputs of the
// ps2_voice_allocator.
//   rx_data        8           scancode byte
//   rx_valid       1           one-cycle strobe marking rx_data valid
//   key_held       18          bitmap of held keys (bit n = note n)
//   voice_active   NUM_VOICES  voice v is sounding
//   voice_key      5*NUM_VOICES note per voice, field v = [5v+4:5v]
//   voice_start    NUM_VOICES  one-cycle retrigger pulse per voice
//   alloc_overflow 1           one-cycle pulse: make found no free voice
//   parse_state    2           debug view of the parser FSM state
//
// Handshake: rx_valid/rx_data is a push-only strobe with no ready. The
// consumer accepts every cycle in which rx_valid is high; the producer
// may assert it on back-to-back cycles and never holds a byte waiting.
//
// Modports: slave = allocator side, master = byte producer / observer.
interface ps2_voice_allocator_if #(
  parameter int NUM_VOICES = 4
);
  logic [7:0]              rx_data;
  logic                    rx_valid;
  logic [17:0]             key_held;
  logic [NUM_VOICES-1:0]   voice_active;
  logic [5*NUM_VOICES-1:0] voice_key;
  logic [NUM_VOICES-1:0]   voice_start;
  logic                    alloc_overflow;
  logic [1:0]              parse_state;

  modport slave (
    input  rx_data, rx_valid,
    output key_held, voice_active, voice_key, voice_start,
           alloc_overflow, parse_state
  );

  modport master (
    output rx_data, rx_valid,
    input  key_held, voice_active, voice_key, voice_start,
           alloc_overflow, parse_state
  );
endinterface

// File: rtl/ps2_voice_allocator.sv
// ps2_voice_allocator
//
// Parses the PS/2 scancode byte stream into make/break events for 18
// synth keys, tracks held keys and shares NUM_VOICES tone generators
// among them with age ranking (rank 0 = youngest).
//
// Ports:
//   clk    system clock
//   reset  asynchronous, active-high; clears all state
//   bus    ps2_voice_allocator_if.slave (rx_data/rx_valid in; key_held,
//          voice_active, voice_key, voice_start, alloc_overflow and the
//          parse_state debug view out)
//
// Build option: define VOICE_STEAL_EN to steal the oldest voice when all
// voices are busy; otherwise the new note is dropped (it is still marked
// held). alloc_overflow pulses in both builds.
module ps2_voice_allocator #(
  parameter int NUM_VOICES = 4
) (
  input logic                   clk,
  input logic                   reset,
  ps2_voice_allocator_if.slave  bus
);

  localparam int RW = $clog2(NUM_VOICES);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    BREAK     = 2'd1,
    EXT       = 2'd2,
    EXT_BREAK = 2'd3
  } state_t;

  state_t                  state_q, state_d;
  logic [17:0]             key_held_q, key_held_d;
  logic [NUM_VOICES-1:0]   voice_active_q, voice_active_d;
  logic [5*NUM_VOICES-1:0] voice_key_q, voice_key_d;
  logic [NUM_VOICES-1:0]   voice_start_q, voice_start_d;
  logic                    alloc_overflow_q, alloc_overflow_d;
  logic [RW-1:0]           rank_q [NUM_VOICES];
  logic [RW-1:0]           rank_d [NUM_VOICES];

  logic [5:0]              map_hit_note;
  logic [4:0]              note;
  logic                    make_ev;
  logic                    brk_ev;
  logic [NUM_VOICES-1:0]   tgt;
  logic                    has_free;
  logic [RW-1:0]           tgt_rank;
  logic                    do_assign;

  // Returns {mapped, note[4:0]}.
  function automatic logic [5:0] map_code(input logic [7:0] code);
    logic [5:0] r;
    case (code)
      8'h1C: r = {1'b1, 5'd0};
      8'h1D: r = {1'b1, 5'd1};
      8'h1B: r = {1'b1, 5'd2};
      8'h24: r = {1'b1, 5'd3};
      8'h23: r = {1'b1, 5'd4};
      8'h2B: r = {1'b1, 5'd5};
      8'h2C: r = {1'b1, 5'd6};
      8'h34: r = {1'b1, 5'd7};
      8'h35: r = {1'b1, 5'd8};
      8'h33: r = {1'b1, 5'd9};
      8'h3C: r = {1'b1, 5'd10};
      8'h3B: r = {1'b1, 5'd11};
      8'h42: r = {1'b1, 5'd12};
      8'h44: r = {1'b1, 5'd13};
      8'h4B: r = {1'b1, 5'd14};
      8'h4D: r = {1'b1, 5'd15};
      8'h4C: r = {1'b1, 5'd16};
      8'h52: r = {1'b1, 5'd17};
      default: r = 6'd0;
    endcase
    return r;
  endfunction

  always_comb begin
    state_d          = state_q;
    key_held_d       = key_held_q;
    voice_active_d   = voice_active_q;
    voice_key_d      = voice_key_q;
    voice_start_d    = '0;
    alloc_overflow_d = 1'b0;
    for (int v = 0; v < NUM_VOICES; v++) rank_d[v] = rank_q[v];

    map_hit_note = map_code(bus.rx_data);
    note         = map_hit_note[4:0];
    make_ev      = 1'b0;
    brk_ev       = 1'b0;

    // Parser: one byte per rx_valid, no stall.
    if (bus.rx_valid) begin
      case (state_q)
        IDLE: begin
          if (bus.rx_data == 8'hF0)      state_d = BREAK;
          else if (bus.rx_data == 8'hE0) state_d = EXT;
          else                           make_ev = map_hit_note[5];
        end
        BREAK: begin
          brk_ev  = map_hit_note[5];
          state_d = IDLE;
        end
        EXT: begin
          if (bus.rx_data == 8'hF0) state_d = EXT_BREAK;
          else                      state_d = IDLE;
        end
        default: state_d = IDLE;  // EXT_BREAK: extended keys are never notes
      endcase
    end

    // Lowest-index free voice (scan high to low so the lowest wins).
    tgt = '0;
    for (int v = NUM_VOICES - 1; v >= 0; v--) begin
      if (!voice_active_q[v]) begin
        tgt    = '0;
        tgt[v] = 1'b1;
      end
    end
    has_free = |tgt;

`ifdef VOICE_STEAL_EN
    // All busy: the oldest voice is the victim.
    if (!has_free) begin
      for (int v = 0; v < NUM_VOICES; v++) begin
        if (rank_q[v] == RW'(NUM_VOICES - 1)) tgt[v] = 1'b1;
      end
    end
`endif

    tgt_rank = '0;
    for (int v = 0; v < NUM_VOICES; v++) begin
      if (tgt[v]) tgt_rank = rank_q[v];
    end

    // A make for an already held key is a typematic repeat and ignored.
    do_assign = 1'b0;
    if (make_ev && !key_held_q[note]) begin
      key_held_d[note] = 1'b1;
      alloc_overflow_d = !has_free;
`ifdef VOICE_STEAL_EN
      do_assign = 1'b1;
`else
      do_assign = has_free;
`endif
    end

    // Assigned voice becomes youngest; voices younger than it age by one,
    // which keeps the ranks a permutation.
    if (do_assign) begin
      for (int v = 0; v < NUM_VOICES; v++) begin
        if (tgt[v]) begin
          voice_key_d[5*v +: 5] = note;
          voice_active_d[v]     = 1'b1;
          voice_start_d[v]      = 1'b1;
          rank_d[v]             = '0;
        end else if (rank_q[v] < tgt_rank) begin
          rank_d[v] = rank_q[v] + 1'b1;
        end
      end
    end

    // Break of a held key silences any voice still playing it; voice_key
    // keeps the old note. A stolen or dropped note simply has no voice.
    if (brk_ev && key_held_q[note]) begin
      key_held_d[note] = 1'b0;
      for (int v = 0; v < NUM_VOICES; v++) begin
        if (voice_active_q[v] && (voice_key_q[5*v +: 5] == note))
          voice_active_d[v] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q          <= IDLE;
      key_held_q       <= '0;
      voice_active_q   <= '0;
      voice_key_q      <= '0;
      voice_start_q    <= '0;
      alloc_overflow_q <= 1'b0;
      for (int v = 0; v < NUM_VOICES; v++) rank_q[v] <= RW'(v);
    end else begin
      state_q          <= state_d;
      key_held_q       <= key_held_d;
      voice_active_q   <= voice_active_d;
      voice_key_q      <= voice_key_d;
      voice_start_q    <= voice_start_d;
      alloc_overflow_q <= alloc_overflow_d;
      for (int v = 0; v < NUM_VOICES; v++) rank_q[v] <= rank_d[v];
    end
  end

  assign bus.key_held       = key_held_q;
  assign bus.voice_active   = voice_active_q;
  assign bus.voice_key      = voice_key_q;
  assign bus.voice_start    = voice_start_q;
  assign bus.alloc_overflow = alloc_overflow_q;
  assign bus.parse_state    = state_q;

endmodule
